spectro_frame_rx: RTL

SPECTRO_FRAME_RX -- requirements
Module: spectro_frame_rx

---
 rtl/spectro_frame_rx_pkg.sv | 25 ++
 rtl/spectro_frame_rx_sipo_shift.sv | 55 +++++
 rtl/spectro_frame_rx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spectro_frame_rx_pkg.sv
// +--------------------------------------------------------------------+
// | spectro_frame_rx_pkg: shared defaults, FSM encoding, RTC fields     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package spectro_frame_rx_pkg;

  localparam int DEF_WORD_W  = 12;
  localparam int DEF_N_WORDS = 16;

  localparam int MIN_MSB = 11;
  localparam int MIN_LSB = 6;
  localparam int SEC_MSB = 5;
  localparam int SEC_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_SL = 2'd1,
    ST_SHIFT   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spectro_frame_rx_sipo_shift.sv
// +--------------------------------------------------------------------+
// | sipo_shift: MSB-first serial-to-parallel shifter with bit counter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module sipo_shift
  import spectro_frame_rx_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              serial_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_o
);

  localparam int CNT_W = $clog2(WORD_W);

  // The final bit is taken straight from serial_i, so only WORD_W-1 bits
  // need storage for the word to be complete on its last sample edge.
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign last_o = (cnt_q == CNT_W'(WORD_W - 1));
  assign word_o = {shift_q, serial_i};

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (en_i) begin
      shift_d = {shift_q[WORD_W-3:0], serial_i};
      cnt_d   = last_o ? '0 : cnt_q + 1'b1;
    end
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spectro_frame_rx.sv
// +--------------------------------------------------------------------+
// | spectro_frame_rx: framed serial word receiver with RTC extraction   |
// | Option: SPECTRO_RX_FRAME_ERR_EN enables the frame_err pulse.        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module spectro_frame_rx
  import spectro_frame_rx_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int N_WORDS = DEF_N_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              sl_in,
  input  logic              ovf_in,
  output logic [WORD_W-1:0] word_data,
  output logic [3:0]        word_idx,
  output logic              word_valid,
  output logic [5:0]        rtc_min,
  output logic [5:0]        rtc_sec,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

`ifdef SPECTRO_RX_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              ovf_q;
  logic [3:0]        word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic [3:0]        word_idx_q, word_idx_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [5:0]        rtc_min_q, rtc_min_d;
  logic [5:0]        rtc_sec_q, rtc_sec_d;

  logic              w_ovf_rise;
  logic              w_err_evt;
  logic              w_sipo_clr;
  logic              w_sipo_en;
  logic [WORD_W-1:0] w_sipo_word;
  logic              w_sipo_last;

  sipo_shift #(
    .WORD_W (WORD_W)
  ) u_sipo (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (w_sipo_clr),
    .en_i     (w_sipo_en),
    .serial_i (serial_in),
    .word_o   (w_sipo_word),
    .last_o   (w_sipo_last)
  );

  assign w_ovf_rise = ovf_in & ~ovf_q;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    word_data_d = word_data_q;
    word_idx_d  = word_idx_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    w_err_evt   = 1'b0;
    rtc_min_d   = rtc_min_q;
    rtc_sec_d   = rtc_sec_q;
    w_sipo_clr  = 1'b0;
    w_sipo_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (w_ovf_rise) begin
          state_d    = ST_WAIT_SL;
          word_cnt_d = '0;
        end
      end

      ST_WAIT_SL: begin
        if (w_ovf_rise) begin
          w_err_evt  = 1'b1;
          word_cnt_d = '0;
        end else if (sl_in) begin
          state_d    = ST_SHIFT;
          w_sipo_clr = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (w_ovf_rise) begin
          // A new trigger always wins, even over a word completing now.
          w_err_evt  = 1'b1;
          word_cnt_d = '0;
          state_d    = ST_WAIT_SL;
          w_sipo_clr = 1'b1;
        end else begin
          w_sipo_en = 1'b1;
          if (w_sipo_last) begin
            word_data_d = w_sipo_word;
            word_idx_d  = word_cnt_q;
            valid_d     = 1'b1;
            if (word_cnt_q == 4'd0) begin
              rtc_min_d = w_sipo_word[MIN_MSB:MIN_LSB];
              rtc_sec_d = w_sipo_word[SEC_MSB:SEC_LSB];
            end
            if (word_cnt_q == 4'(N_WORDS - 1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              word_cnt_d = word_cnt_q + 4'd1;
              if (sl_in) begin
                state_d    = ST_SHIFT;
                w_sipo_clr = 1'b1;
              end else begin
                state_d = ST_WAIT_SL;
              end
            end
          end else if (sl_in) begin
            w_err_evt  = 1'b1;
            w_sipo_clr = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    err_d = ERR_EN & w_err_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ovf_q       <= 1'b0;
      word_cnt_q  <= '0;
      word_data_q <= '0;
      word_idx_q  <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rtc_min_q   <= '0;
      rtc_sec_q   <= '0;
    end else begin
      state_q     <= state_d;
      ovf_q       <= ovf_in;
      word_cnt_q  <= word_cnt_d;
      word_data_q <= word_data_d;
      word_idx_q  <= word_idx_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rtc_min_q   <= rtc_min_d;
      rtc_sec_q   <= rtc_sec_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_idx   = word_idx_q;
  assign word_valid = valid_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign rtc_min    = rtc_min_q;
  assign rtc_sec    = rtc_sec_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire
